// File: rtl/right_rotate_reg.sv
// DW-bit register with parallel load and one-position right rotate per enabled clock.
// Optional even-parity output q_parity is enabled by defining RIGHT_ROTATE_REG_PARITY_EN.
`timescale 1ns/1ps

module right_rotate_reg #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          async_rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q
`ifdef RIGHT_ROTATE_REG_PARITY_EN
  ,
  output logic          q_parity
`endif
);

  logic [DW-1:0] rotated;

  // A one-bit register has nothing to rotate, and the general slice would be empty.
  generate
    if (DW == 1) begin : g_rot_identity
      assign rotated = q;
    end else begin : g_rot_right
      assign rotated = {q[0], q[DW-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (en) begin
      q <= rotated;
    end
  end

`ifdef RIGHT_ROTATE_REG_PARITY_EN
  assign q_parity = ^q;
`endif

endmodule

// File: tb/tb_right_rotate_reg.sv
// Directed scoreboard bench for right_rotate_reg: reset, load/hold, rotate, priority and parity.
`timescale 1ns/1ps

module tb_right_rotate_reg;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          async_rst_n;
  logic          load;
  logic          en;
  logic [DW-1:0] data;
  logic [DW-1:0] q;
`ifdef RIGHT_ROTATE_REG_PARITY_EN
  logic          q_parity;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_queue[$];
  logic [DW-1:0] model_q;
  logic [DW-1:0] rot_exp[5];
  logic [DW-1:0] reload_exp[3];

  right_rotate_reg #(.DW(DW)) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .load        (load),
    .en          (en),
    .data        (data),
    .q           (q)
`ifdef RIGHT_ROTATE_REG_PARITY_EN
    ,
    .q_parity    (q_parity)
`endif
  );

  always #10 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [DW-1:0] observed,
                            input logic [DW-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

`ifdef RIGHT_ROTATE_REG_PARITY_EN
  task automatic checkParity(input string tag, input logic expected);
    tests_run++;
    assert (q_parity === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, q_parity, expected);
    end
  endtask
`endif

  // Drive on the falling edge, advance the reference model, queue the expected q.
  task automatic applyStimulus(input logic l, input logic e, input logic [DW-1:0] d);
    @(negedge clk);
    load = l;
    en   = e;
    data = d;
    if (l)      model_q = d;
    else if (e) model_q = {model_q[0], model_q[DW-1:1]};
    exp_queue.push_back(model_q);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [DW-1:0] expected;
    if (exp_queue.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("[TB] FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      expected = exp_queue.pop_front();
      checkValue(tag, q, expected);
`ifdef RIGHT_ROTATE_REG_PARITY_EN
      checkParity({tag, "_parity"}, ^expected);
`endif
    end
  endtask

  initial begin
    rot_exp    = '{4'b1101, 4'b1110, 4'b0111, 4'b1011, 4'b1101};
    reload_exp = '{4'b1100, 4'b0110, 4'b0011};
    async_rst_n = 1'b0;
    load        = 1'b0;
    en          = 1'b0;
    data        = '0;
    model_q     = '0;

    #3;
    checkValue("reset_initial", q, 4'b0000);
`ifdef RIGHT_ROTATE_REG_PARITY_EN
    checkParity("reset_initial_parity", 1'b0);
`endif
    #2 async_rst_n = 1'b1;

    // Put a nonzero value in so the asynchronous clear is observable.
    applyStimulus(1'b1, 1'b0, 4'b1111);
    checkOutput("preload");

    @(negedge clk);
    load = 1'b0;
    en   = 1'b0;
    #2 async_rst_n = 1'b0;
    #1 checkValue("reset_async_immediate", q, 4'b0000);
    #3 async_rst_n = 1'b1;
    model_q = '0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, DW'($urandom));
      checkOutput("reset_release_hold");
    end

    applyStimulus(1'b1, 1'b0, 4'b1011);
    checkOutput("load_1011");
    checkValue("load_1011_const", q, 4'b1011);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, DW'($urandom));
      checkOutput("hold_1011");
    end

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, DW'($urandom));
      checkOutput("load_random");
      applyStimulus(1'b0, 1'b0, DW'($urandom));
      checkOutput("hold_random");
    end

    applyStimulus(1'b1, 1'b0, 4'b1011);
    checkOutput("load_before_rotate");
`ifdef RIGHT_ROTATE_REG_PARITY_EN
    checkParity("parity_load_1011", 1'b1);
`endif
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, DW'($urandom));
      checkOutput("rotate");
      checkValue("rotate_const", q, rot_exp[i]);
`ifdef RIGHT_ROTATE_REG_PARITY_EN
      checkParity("parity_rotate", 1'b1);
`endif
    end

    applyStimulus(1'b1, 1'b1, 4'b0110);
    checkOutput("priority_load");
    checkValue("priority_load_const", q, 4'b0110);
`ifdef RIGHT_ROTATE_REG_PARITY_EN
    checkParity("parity_load_0110", 1'b0);
`endif
    applyStimulus(1'b0, 1'b1, 4'b1111);
    checkOutput("priority_next_rotate");
    checkValue("priority_next_const", q, 4'b0011);

    // Reach 1101, then assert reset 2 ns before an edge and release 2 ns after it.
    applyStimulus(1'b1, 1'b0, 4'b1011);
    checkOutput("midrot_load");
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("midrot_rotate");
    checkValue("midrot_const", q, 4'b1101);
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
    #8 async_rst_n = 1'b0;
    #1 checkValue("midrot_reset_immediate", q, 4'b0000);
`ifdef RIGHT_ROTATE_REG_PARITY_EN
    checkParity("parity_reset", 1'b0);
`endif
    @(posedge clk);
    #2 async_rst_n = 1'b1;
    #1 checkValue("midrot_reset_release", q, 4'b0000);
    model_q = '0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, DW'($urandom));
      checkOutput("rotate_zero");
    end

    applyStimulus(1'b1, 1'b0, 4'b1001);
    checkOutput("reload_1001");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, DW'($urandom));
      checkOutput("reload_rotate");
      checkValue("reload_rotate_const", q, reload_exp[i]);
    end

    if (exp_queue.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: observed %0d entries expected 0", exp_queue.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
